keypad_scan_4x4: RTL and testbench
==================================

// Module: keypad_scan_4x4
// PURPOSE
//  Input-side counterpart of the 4-digit display multiplexer: scans a 4x4 matrix keypad
//  (PmodKYPD-style) by driving columns 1-cold and reading rows. Debounces each press and
//  emits one 4-bit hex key code per press. Feeds value entry (e.g. sort operands) in the
//  same clk domain. Uses a clock-enable tick, never a derived clock.
// PARAMETERS
//  DIV_W    14  scan tick period = 2^DIV_W clk cycles (tick when divider counter = all ones)
//  DEB_CNT  4   consecutive ticks a press or release must be stable before it is accepted
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  clr_n      in   1  asynchronous, active-low reset
//  row        in   4  keypad rows, active-low (external pull-ups); asynchronous to clk
//  col        out  4  keypad column drive, 1-cold: col[c]=0 selects column c
//  key_code   out  4  hex code of last accepted key; holds until next accepted press
//  key_valid  out  1  one-clk pulse, asserted in the cycle key_code updates
//  key_held   out  1  1 from acceptance of a press until its release is accepted
// BEHAVIOUR
//  Reset (clr_n=0, async): col=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN,
//   divider=0, debounce count=0, column index=0, row synchronizer flops=4'b1111.
//  row passes through a 2-flop synchronizer (rs); all decisions use rs, only on tick cycles.
//  Key map [row][col]: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: 0 F E D.
//  FSM (all transitions on tick only; between ticks state/col/counters hold):
//   SCAN:    rs all 1 -> advance column index (0>1>2>3>0, wrap), col follows.
//            exactly one rs bit low -> latch row idx + col idx, cnt=1, -> DEBOUNCE.
//            >1 rs bit low -> invalid, treated as no press (advance column).
//   DEBOUNCE: col frozen. rs == latched pattern -> cnt+1; when cnt reaches DEB_CNT:
//            key_code<=map[row][col], key_valid=1 for that one clk, key_held<=1, -> HELD.
//            rs differs -> cnt=0, advance column, -> SCAN (no pulse).
//   HELD:    col frozen. latched row bit still 0 -> stay (no repeat pulse, ever).
//            latched row bit 1 -> cnt=1, -> RELEASE.
//   RELEASE: latched row bit 1 -> cnt+1; at DEB_CNT: key_held<=0, advance column, -> SCAN.
//            latched row bit 0 again -> cnt=0, -> HELD (bounce on release, no new pulse).
//  DEB_CNT=1: accept on the detecting tick itself (SCAN -> HELD directly, pulse then).
//  Latency: stable press first seen on tick T -> key_valid on tick T+DEB_CNT-1 (same clk
//   edge as the state update); ~2-3 clk synchronizer delay before T.
//  Column settle: col changes right after a tick; next sample is 2^DIV_W clks later.
//  Other keys pressed while HELD/RELEASE are ignored (only latched column is driven).
//  key_valid is never asserted in two consecutive clks; never asserted outside DEBOUNCE exit.
//  Counter widths: divider DIV_W bits, wraps freely; cnt width $clog2(DEB_CNT+1), saturates.
//  Reset asserted mid-press: all to reset values immediately; after clr_n rises the key is
//   re-detected from SCAN and produces a fresh pulse once debounced.
// STRUCTURE
//  keypad_defs.vh (shared include): FSM state encodings (SCAN, DEBOUNCE, HELD, RELEASE),
//   16-entry key map table, default DIV_W/DEB_CNT.
//  One sub-module: scan_tick_gen #(DIV_W) (clk, clr_n, tick) -- free-running divider, 1-clk
//   tick on all-ones; reusable by the display mux as a clock enable.
//  Top holds synchronizer, FSM, column index/decoder, debounce counter, output registers.
// TESTING  (DIV_W=4, DEB_CNT=3; bench models row[r]=0 iff a pressed key at (r,c) has col[c]=0)
//  1 clr_n low 3 clks mid-DEBOUNCE -> col=1110, key_code=0, key_valid=0, key_held=0 at once;
//    after release col steps 1110>1101>1011>0111>1110 every 16 clks.
//  2 press key '5' (r1,c1), hold 200 clks -> exactly one key_valid, key_code=4'h5,
//    key_held=1, col frozen at 1101 until release.
//  3 key '9' (r2,c2) bouncing: low for 1 tick, high 1 tick, repeated 5x -> no key_valid,
//    key_held stays 0, scanning continues.
//  4 release '5' after test 2 with one release bounce -> key_held falls only after 3 stable
//    high ticks; no second pulse; next col after release = 1011.
//  5 rows r0 and r2 low together in column 0 -> ignored, no key_valid, scan continues.
//  6 press 'D' (r3,c3), release, then '0' (r3,c0) -> two pulses, key_code 4'hD then 4'h0;
//    during 'D' held, also pressing '1' (r0,c0) -> no effect.

Source files
------------

// File: rtl/keypad_scan_4x4_pkg.sv
// Shared definitions for the 4x4 keypad scanner: default timing, FSM states,
// key map and small 1-cold helpers.
package keypad_scan_4x4_pkg;

  localparam int DIV_W_DEF   = 14;
  localparam int DEB_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  // Legend printed on a PmodKYPD, indexed by {row, col}.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // {valid, index}: valid only when exactly one bit of v is low.
  function automatic logic [2:0] decode_row(input logic [3:0] v);
    logic [2:0] res;
    case (v)
      4'b1110: res = 3'b100;
      4'b1101: res = 3'b101;
      4'b1011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_if.sv
// Keypad pins plus decoded key outputs; master is the scanner side.
interface keypad_scan_4x4_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (input row, output col, output key_code, output key_valid, output key_held);
  modport slave  (output row, input col, input key_code, input key_valid, input key_held);
endinterface

// File: rtl/keypad_scan_4x4_tick.sv
// Free-running divider producing a one-clk enable when the counter is all ones;
// shared as a clock enable with the display multiplexer.
module scan_tick_gen #(
  parameter int DIV_W = 14
) (
  input  logic clk,
  input  logic clr_n,
  output logic tick
);

  logic [DIV_W-1:0] div_q, div_d;

  always_comb div_d = div_q + 1'b1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) div_q <= '0;
    else        div_q <= div_d;
  end

  assign tick = &div_q;

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: 1-cold column drive, synchronised row sampling on a
// divider tick, debounced press/release and one key_valid pulse per accepted press.
module keypad_scan_4x4
  import keypad_scan_4x4_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int DEB_CNT = DEB_CNT_DEF
) (
  input logic                clk,
  input logic                clr_n,
  keypad_scan_4x4_if.master  kp
);

  localparam int              CNT_W   = $clog2(DEB_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic tick;

  scan_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .clr_n (clr_n),
    .tick  (tick)
  );

  kp_state_e        state_q, state_d;
  logic [3:0]       rs1_q, rs1_d, rs_q, rs_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic [2:0]       row_dec;
  logic             row_bit;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    rs1_d       = kp.row;
    rs_d        = rs1_q;
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    row_dec = decode_row(rs_q);
    row_bit = rs_q[row_idx_q];
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Everything below only moves on a scan tick; column drive is frozen
    // outside SCAN so only the latched key can be seen.
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (row_dec[2]) begin
            row_idx_d = row_dec[1:0];
            cnt_d     = CNT_ONE;
            if (DEB_CNT <= 1) begin
              key_code_d  = key_map(row_dec[1:0], col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q == one_cold(row_idx_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              key_code_d  = key_map(row_idx_q, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              state_d     = ST_HELD;
            end
          end else begin
            cnt_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (row_bit) begin
            cnt_d = CNT_ONE;
            if (DEB_CNT <= 1) begin
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = ST_SCAN;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (row_bit) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= CNT_MAX) begin
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = ST_SCAN;
            end
          end else begin
            cnt_d   = '0;
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    col_d = one_cold(col_idx_d);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_SCAN;
      rs1_q       <= 4'hF;
      rs_q        <= 4'hF;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cnt_q       <= '0;
      col_q       <= 4'b1110;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs_q        <= rs_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign kp.col       = col_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Bench for keypad_scan_4x4: a keypad model drives rows from the column drive and
// a scoreboard queue of expected key codes is checked on every key_valid pulse.
`timescale 1ns/1ps
module tb_keypad_scan_4x4;

  localparam int DIV_W   = 4;
  localparam int DEB_CNT = 3;

  logic clk   = 1'b0;
  logic clr_n = 1'b0;

  keypad_scan_4x4_if kif();

  keypad_scan_4x4 #(.DIV_W(DIV_W), .DEB_CNT(DEB_CNT)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  logic [3:0] pressed [4];
  int         n_vec     = 0;
  int         n_err     = 0;
  int         pulse_cnt = 0;
  logic [3:0] exp_q [$];
  logic       prev_valid;

  // Keypad model: a row reads low when a pressed key sits on a driven column.
  always_comb begin
    kif.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !kif.col[c]) kif.row[r] = 1'b0;
  end

  // Independent tick timing model: tick edge every 16 clks after reset release.
  logic [DIV_W-1:0] div_m;
  logic             tick_edge;
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div_m     <= '0;
      tick_edge <= 1'b0;
    end else begin
      div_m     <= div_m + 1'b1;
      tick_edge <= (div_m == '1);
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (clr_n) begin
      if (kif.key_valid) begin
        logic [3:0] e;
        pulse_cnt++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: key_code=%h, no press outstanding", kif.key_code);
        end else begin
          e = exp_q.pop_front();
          if (kif.key_code !== e) begin
            n_err++;
            $display("FAIL pulse_code: got %h want %h", kif.key_code, e);
          end
        end
        n_vec++;
        if (prev_valid) begin
          n_err++;
          $display("FAIL back_to_back_valid: key_valid high two clks in a row");
        end
      end
      prev_valid <= kif.key_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  task automatic wait_tick();
    do @(negedge clk); while (!tick_edge);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_c [4];
    exp_c[0] = 4'b1101; exp_c[1] = 4'b1011; exp_c[2] = 4'b0111; exp_c[3] = 4'b1110;
    clr_n = 1'b0;
    wait_clks(3);
    n_vec++; if (kif.col !== 4'b1110) begin n_err++; $display("FAIL rst_col: got %b want 1110", kif.col); end
    n_vec++; if (kif.key_code !== 4'h0) begin n_err++; $display("FAIL rst_code: got %h want 0", kif.key_code); end
    n_vec++; if (kif.key_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", kif.key_valid); end
    n_vec++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL rst_held: got %b want 0", kif.key_held); end
    clr_n = 1'b1;
    wait_clks(8);
    n_vec++; if (kif.col !== 4'b1110) begin n_err++; $display("FAIL pre_tick_col: got %b want 1110", kif.col); end
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      n_vec++;
      if (kif.col !== exp_c[i]) begin n_err++; $display("FAIL scan_step%0d: got %b want %b", i, kif.col, exp_c[i]); end
    end
  endtask

  task automatic test_press_hold();
    int p0, col_bad;
    p0 = pulse_cnt;
    col_bad = 0;
    pressed[1][1] = 1'b1;
    exp_q.push_back(4'h5);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kif.key_held && kif.col !== 4'b1101) col_bad++;
    end
    n_vec++; if (pulse_cnt - p0 != 1) begin n_err++; $display("FAIL hold_pulses: got %0d want 1", pulse_cnt - p0); end
    n_vec++; if (kif.key_code !== 4'h5) begin n_err++; $display("FAIL hold_code: got %h want 5", kif.key_code); end
    n_vec++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL hold_held: got %b want 1", kif.key_held); end
    n_vec++; if (col_bad != 0 || kif.col !== 4'b1101) begin n_err++; $display("FAIL hold_col_frozen: col %b, %0d bad clks, want 1101", kif.col, col_bad); end
  endtask

  task automatic test_release_bounce();
    int p0;
    p0 = pulse_cnt;
    wait_tick(); wait_clks(4);
    pressed[1][1] = 1'b0;
    wait_tick();
    n_vec++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL rel_tickA_held: got %b want 1", kif.key_held); end
    wait_clks(4);
    pressed[1][1] = 1'b1;
    wait_tick();
    n_vec++; if (kif.key_held !== 1'b1) begin n_err++; $display("FAIL rel_bounce_held: got %b want 1", kif.key_held); end
    wait_clks(4);
    pressed[1][1] = 1'b0;
    wait_tick();
    wait_tick();
    n_vec++; if (kif.key_held !== 1'b1 || kif.col !== 4'b1101) begin n_err++; $display("FAIL rel_two_stable: held %b col %b, want 1 and 1101", kif.key_held, kif.col); end
    wait_tick();
    n_vec++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL rel_three_stable_held: got %b want 0", kif.key_held); end
    n_vec++; if (kif.col !== 4'b1011) begin n_err++; $display("FAIL rel_next_col: got %b want 1011", kif.col); end
    n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL rel_no_pulse: got %0d pulses want 0", pulse_cnt - p0); end
  endtask

  task automatic test_reset_mid_debounce();
    logic [3:0] exp_c [4];
    bit found;
    exp_c[0] = 4'b1101; exp_c[1] = 4'b1011; exp_c[2] = 4'b0111; exp_c[3] = 4'b1110;
    found = 1'b0;
    pressed[0][0] = 1'b1;
    for (int i = 0; i < 8 && !found; i++) begin
      wait_tick();
      if (kif.col === 4'b1110) found = 1'b1;
    end
    n_vec++; if (!found) begin n_err++; $display("FAIL mid_deb_reach_col0: col %b, want 1110 within 8 ticks", kif.col); end
    wait_tick();
    wait_clks(6);
    clr_n = 1'b0;
    #1;
    n_vec++; if (kif.col !== 4'b1110) begin n_err++; $display("FAIL mid_rst_col: got %b want 1110", kif.col); end
    n_vec++; if (kif.key_code !== 4'h0) begin n_err++; $display("FAIL mid_rst_code: got %h want 0", kif.key_code); end
    n_vec++; if (kif.key_valid !== 1'b0 || kif.key_held !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags: valid %b held %b want 0 0", kif.key_valid, kif.key_held); end
    pressed[0][0] = 1'b0;
    wait_clks(3);
    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      n_vec++;
      if (kif.col !== exp_c[i]) begin n_err++; $display("FAIL post_rst_step%0d: got %b want %b", i, kif.col, exp_c[i]); end
    end
  endtask

  task automatic test_bounce_no_press();
    int p0;
    bit found;
    logic [3:0] col_a;
    p0 = pulse_cnt;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      wait_tick();
      if (kif.col === 4'b1011) found = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      wait_clks(4);
      pressed[2][2] = 1'b1;
      wait_tick();
      wait_clks(4);
      pressed[2][2] = 1'b0;
      wait_tick();
    end
    n_vec++; if (pulse_cnt != p0) begin n_err++; $display("FAIL bounce_no_pulse: got %0d pulses want 0", pulse_cnt - p0); end
    n_vec++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL bounce_held: got %b want 0", kif.key_held); end
    wait_tick();
    col_a = kif.col;
    wait_tick();
    n_vec++; if (kif.col !== next_col(col_a)) begin n_err++; $display("FAIL bounce_scan_continues: got %b want %b", kif.col, next_col(col_a)); end
  endtask

  task automatic test_multi_row();
    int p0;
    logic [3:0] col_a;
    p0 = pulse_cnt;
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
    repeat (8) wait_tick();
    n_vec++; if (pulse_cnt != p0 || kif.key_held !== 1'b0) begin n_err++; $display("FAIL multi_row_ignored: pulses %0d held %b want 0 0", pulse_cnt - p0, kif.key_held); end
    col_a = kif.col;
    wait_tick();
    n_vec++; if (kif.col !== next_col(col_a)) begin n_err++; $display("FAIL multi_row_scan: got %b want %b", kif.col, next_col(col_a)); end
    pressed[0][0] = 1'b0;
    pressed[2][0] = 1'b0;
    wait_tick();
  endtask

  task automatic test_back_to_back();
    int p0, n;
    bit found;
    p0 = pulse_cnt;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      wait_tick();
      if (kif.col === 4'b0111) found = 1'b1;
    end
    wait_clks(4);
    pressed[3][3] = 1'b1;
    exp_q.push_back(4'hD);
    wait_tick();
    wait_tick();
    n_vec++; if (kif.key_held !== 1'b0 || kif.key_valid !== 1'b0) begin n_err++; $display("FAIL d_early: held %b valid %b want 0 0", kif.key_held, kif.key_valid); end
    wait_tick();
    n_vec++; if (kif.key_valid !== 1'b1 || kif.key_held !== 1'b1) begin n_err++; $display("FAIL d_latency: valid %b held %b want 1 1", kif.key_valid, kif.key_held); end
    pressed[0][0] = 1'b1;
    repeat (5) wait_tick();
    n_vec++; if (kif.col !== 4'b0111 || kif.key_held !== 1'b1 || kif.key_code !== 4'hD) begin n_err++; $display("FAIL d_other_key: col %b held %b code %h want 0111 1 d", kif.col, kif.key_held, kif.key_code); end
    pressed[3][3] = 1'b0;
    pressed[0][0] = 1'b0;
    n = 0;
    while (kif.key_held && n < 200) begin @(negedge clk); n++; end
    n_vec++; if (kif.key_held !== 1'b0) begin n_err++; $display("FAIL d_release_timeout: held %b want 0", kif.key_held); end
    pressed[3][0] = 1'b1;
    exp_q.push_back(4'h0);
    n = 0;
    while (!kif.key_held && n < 200) begin @(negedge clk); n++; end
    n_vec++; if (kif.key_held !== 1'b1 || kif.key_code !== 4'h0) begin n_err++; $display("FAIL zero_press: held %b code %h want 1 0", kif.key_held, kif.key_code); end
    pressed[3][0] = 1'b0;
    n = 0;
    while (kif.key_held && n < 200) begin @(negedge clk); n++; end
    wait_clks(2);
    n_vec++; if (pulse_cnt - p0 != 2) begin n_err++; $display("FAIL two_pulses: got %0d want 2", pulse_cnt - p0); end
  endtask

  initial begin
    for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    test_reset();
    test_press_hold();
    test_release_bounce();
    test_reset_mid_debounce();
    test_bounce_no_press();
    test_multi_row();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d codes never seen", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
